// File: rtl/frame_write_sched_pkg.sv
// Shared definitions for the frame write scheduler: pixel-pair packing and FSM state type.
package frame_write_sched_pkg;

    localparam int CH_W     = 8;
    localparam int PIX_W    = 3 * CH_W;
    localparam int PAIR_W   = 2 * PIX_W;
    localparam int ODD_OFS  = PIX_W;   // {R0,G0,B0} occupies the upper half of a pair
    localparam int EVEN_OFS = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    function automatic logic [PAIR_W-1:0] pack_pair(input logic [PIX_W-1:0] odd_pix,
                                                     input logic [PIX_W-1:0] even_pix);
        logic [PAIR_W-1:0] p;
        p = '0;
        p[ODD_OFS  +: PIX_W] = odd_pix;
        p[EVEN_OFS +: PIX_W] = even_pix;
        return p;
    endfunction

endpackage

// File: rtl/frame_write_sched_fifo.sv
// Synchronous pixel-pair FIFO with flush; pointers carry one extra wrap bit.
module frame_write_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/frame_write_sched.sv
// Frame scheduler: buffers upstream pixel pairs and emits one frame of hsync-qualified pairs
// with idle gaps between rows, row/col tracking, frame_done pulse and abort.
module frame_write_sched
    import frame_write_sched_pkg::*;
#(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int ROW_GAP    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int COLS      = WIDTH / 2,
    localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PAIR_W-1:0] in_pix,
    output logic              out_hsync,
    output logic [PAIR_W-1:0] out_pix,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              busy,
    output logic              frame_done
);

    localparam int TOTAL = COLS * HEIGHT;
    localparam int ACC_W = $clog2(TOTAL + 1);
    localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [ACC_W-1:0] ACC_TOTAL = ACC_W'(TOTAL);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [ACC_W-1:0]  accepted;
    logic [GAP_W-1:0]  gap_cnt;
    logic              pop;
    logic              push;
    logic              flush;
    logic              full;
    logic              empty;
    logic [PAIR_W-1:0] rdata;
    logic              last_col;
    logic              last_row;
    logic              all_accepted;

    assign last_col     = (col == COL_LAST);
    assign last_row     = (row == ROW_LAST);
    assign all_accepted = (accepted == ACC_TOTAL);
    assign push         = in_valid && in_ready;

    frame_write_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (PAIR_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (in_pix),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        in_ready   = 1'b0;
        flush      = abort;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACTIVE;
                    flush      = 1'b1;
                end
            end
            ACTIVE: begin
                in_ready = !full && !all_accepted;
                pop      = !empty && !abort;
                if (pop && last_col) begin
                    if (last_row)         next_state = DONE;
                    else if (ROW_GAP > 0) next_state = GAP;
                end
            end
            GAP: begin
                in_ready = !full && !all_accepted;
                if (gap_cnt == GAP_LAST) next_state = ACTIVE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Abort overrides every other transition, including a pending start.
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            row        <= '0;
            col        <= '0;
            accepted   <= '0;
            gap_cnt    <= '0;
            out_hsync  <= 1'b0;
            out_pix    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (abort) begin
            row        <= '0;
            col        <= '0;
            accepted   <= '0;
            gap_cnt    <= '0;
            out_hsync  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_hsync  <= pop;
            frame_done <= (state == DONE);
            gap_cnt    <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (pop) out_pix <= rdata;
            if (push) accepted <= accepted + 1'b1;
            // Row stops at the last row so it never wraps past the frame.
            if (pop) begin
                if (last_col) begin
                    col <= '0;
                    if (!last_row) row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state == IDLE && start) begin
                busy     <= 1'b1;
                row      <= '0;
                col      <= '0;
                accepted <= '0;
            end
            if (state == DONE) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_write_sched.sv
// Bench for frame_write_sched: three configurations, directed tables/sequences plus a
// queue-based reference model that tracks accepted pairs, emission order, row/col and frame_done.
module tb_frame_write_sched;
    import frame_write_sched_pkg::*;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESETn;
    logic        abort;
    logic        in_valid;
    logic [47:0] in_pix;
    logic        start0, start1, start2;

    logic        rdy0, hs0, busy0, done0;
    logic [47:0] pix0;
    logic [0:0]  row0, col0;
    logic        rdy1, hs1, busy1, done1;
    logic [47:0] pix1;
    logic [1:0]  row1, col1;
    logic        rdy2, hs2, busy2, done2;
    logic [47:0] pix2;
    logic [6:0]  row2;
    logic [5:0]  col2;

    frame_write_sched #(.WIDTH(4), .HEIGHT(2), .ROW_GAP(2), .FIFO_DEPTH(4)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start0), .abort(abort), .in_valid(in_valid),
        .in_ready(rdy0), .in_pix(in_pix), .out_hsync(hs0), .out_pix(pix0), .row(row0),
        .col(col0), .busy(busy0), .frame_done(done0));

    frame_write_sched #(.WIDTH(8), .HEIGHT(3), .ROW_GAP(8), .FIFO_DEPTH(4)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start1), .abort(abort), .in_valid(in_valid),
        .in_ready(rdy1), .in_pix(in_pix), .out_hsync(hs1), .out_pix(pix1), .row(row1),
        .col(col1), .busy(busy1), .frame_done(done1));

    frame_write_sched u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start2), .abort(abort), .in_valid(in_valid),
        .in_ready(rdy2), .in_pix(in_pix), .out_hsync(hs2), .out_pix(pix2), .row(row2),
        .col(col2), .busy(busy2), .frame_done(done2));

    // Selected-instance view used by the model and the drivers.
    int          sel;
    logic        rdy_s, hs_s, busy_s, done_s, start_s;
    logic [47:0] pix_s;
    int          row_s, col_s, p_c, p_h, p_g, p_total;

    always_comb begin
        rdy_s = 1'b0; hs_s = 1'b0; busy_s = 1'b0; done_s = 1'b0; start_s = 1'b0;
        pix_s = '0; row_s = 0; col_s = 0; p_c = 2; p_h = 2; p_g = 2;
        case (sel)
            0: begin
                rdy_s = rdy0; hs_s = hs0; busy_s = busy0; done_s = done0; start_s = start0;
                pix_s = pix0; row_s = int'(row0); col_s = int'(col0); p_c = 2; p_h = 2; p_g = 2;
            end
            1: begin
                rdy_s = rdy1; hs_s = hs1; busy_s = busy1; done_s = done1; start_s = start1;
                pix_s = pix1; row_s = int'(row1); col_s = int'(col1); p_c = 4; p_h = 3; p_g = 8;
            end
            default: begin
                rdy_s = rdy2; hs_s = hs2; busy_s = busy2; done_s = done2; start_s = start2;
                pix_s = pix2; row_s = int'(row2); col_s = int'(col2); p_c = 50; p_h = 100; p_g = 2;
            end
        endcase
        p_total = p_c * p_h;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [47:0] exp_q[$];
    int acc_cnt = 0, emit_cnt = 0, done_cnt = 0, hs_total = 0, bp_cnt = 0;
    int cyc = 0, last_hs_cyc = 0, nxt = 0;
    bit m_busy = 0, done_due = 0, last_now = 0, nb = 0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            exp_q.delete();
            acc_cnt = 0; emit_cnt = 0; m_busy = 0; done_due = 0;
        end else begin
            cyc++;
            check("busy", busy_s, m_busy);
            check("frame_done", done_s, done_due);
            if (done_s) done_cnt++;
            checks++;
            if (rdy_s && (!m_busy || acc_cnt >= p_total)) begin
                failures++;
                $display("FAIL in_ready_rule: got 1 expected 0 (busy %0d accepted %0d of %0d)",
                         m_busy, acc_cnt, p_total);
            end
            nb = m_busy;
            last_now = 0;
            if (hs_s) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_hsync: got hsync with nothing outstanding, expected none");
                end else begin
                    check("out_pix", pix_s, exp_q.pop_front());
                end
                nxt = emit_cnt + 1;
                if (nxt >= p_total) begin
                    check("row_end", row_s, p_h - 1);
                    check("col_end", col_s, 0);
                end else begin
                    check("row", row_s, nxt / p_c);
                    check("col", col_s, nxt % p_c);
                end
                if (emit_cnt > 0 && emit_cnt % p_c == 0)
                    check("row_gap_ok", (cyc - last_hs_cyc) > p_g, 1);
                last_hs_cyc = cyc;
                emit_cnt++;
                if (emit_cnt == p_total) begin
                    last_now = 1; nb = 0;
                end
            end
            // Upstream is only refused when the buffer holds FIFO_DEPTH pairs.
            if (in_valid && !rdy_s && m_busy && acc_cnt < p_total) begin
                bp_cnt++;
                check("fifo_full_on_refusal", acc_cnt - emit_cnt, 4);
            end
            if (in_valid && rdy_s) begin
                exp_q.push_back(in_pix);
                acc_cnt++;
            end
            done_due = last_now;
            if (start_s && !m_busy && !abort) begin
                nb = 1; exp_q.delete(); acc_cnt = 0; emit_cnt = 0;
            end
            if (abort) begin
                nb = 0; done_due = 0; exp_q.delete(); acc_cnt = 0; emit_cnt = 0;
            end
            m_busy = nb;
        end
    end

    // Drivers: all start from 1 time unit after a rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_start(input logic v);
        case (sel)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic pulse_start();
        set_start(1'b1);
        tick();
        set_start(1'b0);
    endtask

    task automatic send_pair(input logic [47:0] d);
        bit ok;
        int n;
        ok = 0; n = 0;
        in_valid = 1'b1;
        in_pix = d;
        while (!ok && n < 200) begin
            @(negedge HCLK);
            if (rdy_s) ok = 1;
            tick();
            n++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, expected 1");
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        int n;
        seen = 0; n = 0;
        in_valid = 1'b0;
        while (!seen && n < budget) begin
            @(negedge HCLK);
            if (done_s) seen = 1;
            n++;
        end
        check("frame_done_seen", seen, 1);
        tick();
    endtask

    function automatic logic [47:0] rnd_pair();
        logic [47:0] d;
        d[47:16] = $urandom();
        d[15:0]  = 16'($urandom());
        return d;
    endfunction

    typedef struct {
        bit start;
        bit valid;
        bit exp_rdy;
        bit exp_hs;
        int exp_row;
        bit exp_busy;
        bit exp_done;
    } vec_t;

    vec_t tv[11];
    int   k;
    int   abort_at;

    initial begin
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 1, 0, 0, 1, 0};
        tv[2]  = '{0, 1, 1, 0, 0, 1, 0};
        tv[3]  = '{0, 1, 1, 1, 0, 1, 0};
        tv[4]  = '{0, 1, 1, 1, 1, 1, 0};
        tv[5]  = '{0, 0, 0, 0, 1, 1, 0};
        tv[6]  = '{0, 0, 0, 0, 1, 1, 0};
        tv[7]  = '{0, 0, 0, 1, 1, 1, 0};
        tv[8]  = '{0, 0, 0, 1, 1, 1, 0};
        tv[9]  = '{0, 0, 0, 0, 1, 0, 1};
        tv[10] = '{0, 0, 0, 0, 1, 0, 0};

        sel = 0; HRESETn = 1'b0; abort = 1'b0; in_valid = 1'b0; in_pix = '0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_busy", busy_s, 0);
            check("rst_hsync", hs_s, 0);
            check("rst_done", done_s, 0);
            check("rst_ready", rdy_s, 0);
            check("rst_row", row_s, 0);
            check("rst_col", col_s, 0);
            check("rst_pix", pix_s, 0);
        end
        sel = 0;
        tick();
        HRESETn = 1'b1;
        tick();

        // Test 1: back-to-back frame on 4x2, ROW_GAP=2, cycle by cycle.
        k = 0;
        for (int i = 0; i < 11; i++) begin
            start0 = tv[i].start;
            in_valid = tv[i].valid;
            if (tv[i].valid) begin
                in_pix = pack_pair(24'(2 * k + 1), 24'(2 * k));
                k++;
            end
            @(negedge HCLK);
            check($sformatf("t1_ready[%0d]", i), rdy_s, tv[i].exp_rdy);
            check($sformatf("t1_hsync[%0d]", i), hs_s, tv[i].exp_hs);
            check($sformatf("t1_row[%0d]", i), row_s, tv[i].exp_row);
            check($sformatf("t1_busy[%0d]", i), busy_s, tv[i].exp_busy);
            check($sformatf("t1_done[%0d]", i), done_s, tv[i].exp_done);
            tick();
        end
        start0 = 1'b0; in_valid = 1'b0;

        // Test 2: upstream stall mid-row.
        hs_total = 0; done_cnt = 0;
        pulse_start();
        send_pair(rnd_pair());
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge HCLK);
        check("t2_col_hold", col_s, 1);
        check("t2_row_hold", row_s, 0);
        check("t2_hsync_stall", hs_s, 0);
        tick();
        for (int i = 0; i < 3; i++) send_pair(rnd_pair());
        wait_done(100);
        check("t2_hsyncs", hs_total, 4);
        check("t2_done_cnt", done_cnt, 1);

        // Test 3: buffer fills during a long row gap.
        sel = 1; hs_total = 0; done_cnt = 0; bp_cnt = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) send_pair(rnd_pair());
        wait_done(200);
        check("t3_backpressure_seen", bp_cnt > 0, 1);
        check("t3_hsyncs", hs_total, 12);
        check("t3_leftover", exp_q.size(), 0);
        check("t3_done_cnt", done_cnt, 1);

        // Test 4: abort after three accepted pairs, then a clean frame.
        sel = 0; hs_total = 0; done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 3; i++) send_pair(rnd_pair());
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge HCLK);
        check("t4_busy", busy_s, 0);
        check("t4_hsync", hs_s, 0);
        check("t4_row", row_s, 0);
        check("t4_col", col_s, 0);
        check("t4_ready", rdy_s, 0);
        tick();
        repeat (6) tick();
        check("t4_no_done", done_cnt, 0);
        hs_total = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_pair(rnd_pair());
        wait_done(100);
        check("t4_clean_hsyncs", hs_total, 4);
        check("t4_clean_done", done_cnt, 1);

        // Test 5: start while busy, then start together with abort.
        hs_total = 0; done_cnt = 0;
        pulse_start();
        send_pair(rnd_pair());
        start0 = 1'b1;
        send_pair(rnd_pair());
        start0 = 1'b0;
        send_pair(rnd_pair());
        send_pair(rnd_pair());
        wait_done(100);
        check("t5_hsyncs", hs_total, 4);
        check("t5_done_cnt", done_cnt, 1);
        start0 = 1'b1; abort = 1'b1;
        tick();
        start0 = 1'b0; abort = 1'b0;
        @(negedge HCLK);
        check("t5_idle_busy", busy_s, 0);
        check("t5_idle_ready", rdy_s, 0);
        tick();

        // Asynchronous reset in the middle of a frame.
        pulse_start();
        send_pair(rnd_pair());
        send_pair(rnd_pair());
        in_valid = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        check("arst_busy", busy_s, 0);
        check("arst_hsync", hs_s, 0);
        check("arst_row", row_s, 0);
        check("arst_col", col_s, 0);
        check("arst_ready", rdy_s, 0);
        check("arst_pix", pix_s, 0);
        tick();
        HRESETn = 1'b1;
        tick();

        // Randomized frames with upstream gaps and one random abort.
        sel = 1;
        for (int f = 0; f < 3; f++) begin
            done_cnt = 0; hs_total = 0;
            abort_at = (f == 1) ? int'($urandom_range(1, 10)) : -1;
            pulse_start();
            for (int i = 0; i < 12; i++) begin
                if (i == abort_at) break;
                send_pair(rnd_pair());
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            if (abort_at >= 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                repeat (4) tick();
                check("rnd_abort_no_done", done_cnt, 0);
            end else begin
                wait_done(300);
                check("rnd_hsyncs", hs_total, 12);
                check("rnd_done_cnt", done_cnt, 1);
            end
        end

        // Test 6: default 100x100 frame with incrementing pixel data.
        sel = 2; hs_total = 0; done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 5000; i++) send_pair(pack_pair(24'(2 * i), 24'(2 * i + 1)));
        wait_done(2000);
        check("t6_hsyncs", hs_total, 5000);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_leftover", exp_q.size(), 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
